// File: rtl/jk_pkg.sv
// Shared types for the JK stimulus sequencer: op encoding, command payload,
// player states and the JK next-state rule used by the shadow model.
package jk_pkg;

    localparam int unsigned JK_CNT_W = 4;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TOG  = 2'b11
    } jk_op_e;

    typedef struct packed {
        jk_op_e                op;
        logic [JK_CNT_W-1:0]   count;
    } jk_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } jk_seq_state_e;

    // Next q of a JK flop given its current q and the sampled j/k levels.
    function automatic logic jk_next_q(input logic q, input logic j, input logic k);
        logic nq;
        nq = q;
        case ({j, k})
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            2'b11:   nq = ~q;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = jk_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    T            r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/jk_stim_sequencer.sv
// Buffers JK commands and plays them out as registered j/k levels, while a
// shadow copy of the flop checks the q fed back and counts mismatches.
module jk_stim_sequencer
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = JK_CNT_W,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    output logic             jk_rst_n,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    output logic             busy,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    typedef struct packed {
        jk_op_e           op;
        logic [CNT_W-1:0] count;
    } cmd_t;

    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    jk_seq_state_e    r_state;
    jk_op_e           r_op;
    logic [CNT_W-1:0] r_remaining;
    logic             r_j;
    logic             r_k;
    logic             r_jk_rst_n;
    logic             r_exp_q;
    logic             r_chk_en;
    logic             r_err;
    logic [ERR_W-1:0] r_err_count;

    assign w_push_cmd = '{op: jk_op_e'(cmd_op), count: cmd_count};
    assign cmd_ready  = ~rst & ~w_full;
    assign w_push     = cmd_valid & cmd_ready;
    // Pop whenever the player is free to take the next command this cycle.
    assign w_pop      = ~rst & ~w_empty &
                        ((r_state == IDLE) | (r_remaining == '0));

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty)
    );

    // Player FSM: j/k lag the loaded op by one cycle, so a RUN cycle maps to one drive cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= HOLD;
            r_remaining <= '0;
            r_j         <= 1'b0;
            r_k         <= 1'b0;
        end else begin
            {r_j, r_k} <= (r_state == RUN) ? r_op : 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_op        <= w_head.op;
                        r_remaining <= w_head.count;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (r_remaining != '0) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end else if (w_pop) begin
                        r_op        <= w_head.op;
                        r_remaining <= w_head.count;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Shadow flop and checker; checking starts once the flop has left reset for a full cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jk_rst_n  <= 1'b0;
            r_exp_q     <= 1'b0;
            r_chk_en    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_jk_rst_n <= 1'b1;
            r_chk_en   <= r_chk_en | r_jk_rst_n;
            r_exp_q    <= r_jk_rst_n ? jk_next_q(r_exp_q, r_j, r_k) : 1'b0;
            if (r_chk_en && (q_in != r_exp_q)) begin
                r_err <= 1'b1;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
            end
        end
    end

    assign jk_rst_n  = r_jk_rst_n;
    assign j         = r_j;
    assign k         = r_k;
    assign busy      = ~rst & ((r_state == RUN) | ~w_empty);
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_jk_stim_sequencer.sv
// Bench for jk_stim_sequencer: two instances (ERR_W 8 and 2) each driving a
// JK flop, checked every cycle against a timeline model of the command stream.
module tb_jk_stim_sequencer;
    import jk_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             flip;

    logic       cmd_ready1, jk_rst_n1, j1, k1, busy1, err1, q_ff1, q_in1;
    logic [7:0] err_count1;
    logic       cmd_ready2, jk_rst_n2, j2, k2, busy2, err2, q_ff2, q_in2;
    logic [1:0] err_count2;

    int total = 0;
    int bad   = 0;

    jk_stim_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ERR_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .cmd_ready(cmd_ready1), .jk_rst_n(jk_rst_n1), .j(j1), .k(k1), .q_in(q_in1),
        .busy(busy1), .err(err1), .err_count(err_count1)
    );

    jk_stim_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .cmd_ready(cmd_ready2), .jk_rst_n(jk_rst_n2), .j(j2), .k(k2), .q_in(q_in2),
        .busy(busy2), .err(err2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The JK flops being driven, with an injectable inversion on the feedback path.
    always @(posedge clk or negedge jk_rst_n1) begin
        if (!jk_rst_n1) q_ff1 <= 1'b0;
        else begin
            case ({j1, k1})
                2'b01:   q_ff1 <= 1'b0;
                2'b10:   q_ff1 <= 1'b1;
                2'b11:   q_ff1 <= ~q_ff1;
                default: q_ff1 <= q_ff1;
            endcase
        end
    end
    always @(posedge clk or negedge jk_rst_n2) begin
        if (!jk_rst_n2) q_ff2 <= 1'b0;
        else begin
            case ({j2, k2})
                2'b01:   q_ff2 <= 1'b0;
                2'b10:   q_ff2 <= 1'b1;
                2'b11:   q_ff2 <= ~q_ff2;
                default: q_ff2 <= q_ff2;
            endcase
        end
    end
    assign q_in1 = q_ff1 ^ flip;
    assign q_in2 = q_ff2 ^ flip;

    // Model: each accepted command owns a drive window [s, s+c] on the edge timeline.
    typedef struct {
        int         p;
        int         s;
        int         c;
        logic [1:0] op;
    } mcmd_t;

    mcmd_t mq[$];
    int    cyc         = 0;
    int    last_end    = -10;
    int    rst_low_run = 0;
    int    e1          = 0;
    int    e2          = 0;
    logic  m_q         = 1'b0;
    logic  m_jkrstn    = 1'b0;
    bit    acc         = 1'b0;
    bit    dut_acc     = 1'b0;

    function automatic logic [1:0] f_jk(input int t);
        foreach (mq[i]) if (t >= mq[i].s && t <= mq[i].s + mq[i].c) return mq[i].op;
        return 2'b00;
    endfunction

    function automatic bit f_busy(input int t);
        foreach (mq[i]) if (mq[i].p <= t && t <= mq[i].s + mq[i].c - 1) return 1'b1;
        return 1'b0;
    endfunction

    // Commands in the FIFO just before edge t: accepted earlier, popped at edge s-1 or later.
    function automatic bit f_ready(input int t);
        int occ;
        occ = 0;
        foreach (mq[i]) if (mq[i].p <= t - 1 && mq[i].s > t) occ++;
        return occ < DEPTH;
    endfunction

    function automatic logic f_apply(input logic q, input logic [1:0] op);
        case (op)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit         rst_pre;
        bit         push;
        bit         chk_ok;
        logic [1:0] jk_prev;
        int         s;
        #1;
        rst_pre = rst;
        push    = !rst && cmd_valid && f_ready(cyc + 1);
        dut_acc = cmd_valid && cmd_ready1;
        chk_ok  = (rst_low_run >= 2);
        @(posedge clk);
        cyc++;
        jk_prev = f_jk(cyc - 1);
        m_q = m_jkrstn ? f_apply(m_q, jk_prev) : 1'b0;
        m_jkrstn = !rst_pre;
        if (rst_pre) begin
            mq.delete();
            last_end    = -10;
            rst_low_run = 0;
            e1          = 0;
            e2          = 0;
            m_q         = 1'b0;
        end else begin
            rst_low_run++;
            if (flip && chk_ok) begin
                if (e1 < 255) e1++;
                if (e2 < 3) e2++;
            end
        end
        if (push) begin
            s = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            mq.push_back('{p: cyc, s: s, c: int'(cmd_count), op: cmd_op});
            last_end = s + int'(cmd_count);
        end
        acc = push;
        #1;
        chk("j",         32'(j1),          32'(f_jk(cyc) >> 1));
        chk("k",         32'(k1),          32'(f_jk(cyc) & 2'b01));
        chk("jk_rst_n",  32'(jk_rst_n1),   32'(m_jkrstn));
        chk("busy",      32'(busy1),       32'(!rst && f_busy(cyc)));
        chk("cmd_ready", 32'(cmd_ready1),  32'(!rst && f_ready(cyc + 1)));
        chk("q",         32'(q_ff1),       32'(m_q));
        chk("err",       32'(err1),        32'(e1 != 0));
        chk("err_count", 32'(err_count1),  32'(e1));
        chk("q_w2",      32'(q_ff2),       32'(m_q));
        chk("err_w2",    32'(err2),        32'(e2 != 0));
        chk("errcnt_w2", 32'(err_count2),  32'(e2));
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [CNT_W-1:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = c;
        do begin
            step();
            n++;
        end while (!acc && n < 200);
        cmd_valid = 1'b0;
        chk("push_handshake", 32'(dut_acc), 32'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (f_busy(cyc) && n < 300) begin
            step();
            n++;
        end
        step();
        chk("drain_idle", 32'(busy1), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_hi;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        flip      = 1'b0;

        // Reset, then a reset landing in the middle of a TOG command.
        repeat (3) step();
        chk("init_jk_rst_n", 32'(jk_rst_n1), 32'(0));
        rst = 1'b0;
        repeat (2) step();
        push_cmd(TOG, 4'd5);
        repeat (3) step();
        chk("t1_toggling", 32'({j1, k1}), 32'(2'b11));
        rst = 1'b1;
        repeat (3) step();
        chk("t1_busy", 32'(busy1), 32'(0));
        chk("t1_jk", 32'({j1, k1}), 32'(0));
        chk("t1_err", 32'(err1), 32'(0));
        rst = 1'b0;
        step();
        chk("t1_ready", 32'(cmd_ready1), 32'(1));
        chk("t1_empty", 32'(busy1), 32'(0));

        // Single SET into an idle player.
        push_cmd(SET, 4'd2);
        n_hi = 0;
        repeat (6) begin
            step();
            if (j1 === 1'b1 && k1 === 1'b0) n_hi++;
        end
        chk("t2_set_cycles", 32'(n_hi), 32'(3));
        chk("t2_q", 32'(q_ff1), 32'(1));
        chk("t2_busy", 32'(busy1), 32'(0));

        // Back-to-back commands.
        push_cmd(SET, 4'd0);
        push_cmd(TOG, 4'd3);
        push_cmd(CLR, 4'd1);
        drain();
        chk("t3_q", 32'(q_ff1), 32'(0));
        chk("t3_err", 32'(err1), 32'(0));

        // Fill the FIFO behind a long HOLD.
        push_cmd(HOLD, 4'd15);
        push_cmd(SET, 4'd1);
        push_cmd(CLR, 4'd2);
        push_cmd(TOG, 4'd3);
        push_cmd(HOLD, 4'd0);
        chk("t4_full", 32'(cmd_ready1), 32'(0));
        push_cmd(SET, 4'd4);
        drain();
        chk("t4_q", 32'(q_ff1), 32'(1));

        // Inverted feedback for two cycles during TOG.
        push_cmd(TOG, 4'd7);
        repeat (3) step();
        flip = 1'b1;
        repeat (2) step();
        flip = 1'b0;
        drain();
        chk("t5_err", 32'(err1), 32'(1));
        chk("t5_err_count", 32'(err_count1), 32'(2));
        repeat (5) step();
        chk("t5_sticky", 32'(err1), 32'(1));

        // Five mismatches: the 2-bit counter saturates.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        push_cmd(TOG, 4'd9);
        repeat (2) step();
        flip = 1'b1;
        repeat (5) step();
        flip = 1'b0;
        drain();
        chk("t6_sat", 32'(err_count2), 32'(3));
        chk("t6_wide", 32'(err_count1), 32'(5));

        // Random command stream with gaps, occasional faults and one reset.
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                step();
            end
            repeat ($urandom_range(0, 3)) begin
                flip = ($urandom_range(0, 9) == 0);
                step();
            end
            flip = 1'b0;
            push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        drain();
        chk("rand_end_busy", 32'(busy1), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
